// File: rtl/ponto_flt_pkg.sv
// Shared definitions for the single-precision floating-point back-end:
// FSM states, binary32 field widths, mantissa bit positions and special encodings.
package ponto_flt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } estado_t;

    localparam int unsigned EXP_BITS  = 8;
    localparam int unsigned FRAC_BITS = 23;
    localparam int          BIAS      = 127;
    localparam int          EXP_MAX   = 255;

    // Positions inside the wide mantissa: carry, hidden, fraction LSB, then G/R/S.
    localparam int unsigned BIT_CARRY  = 27;
    localparam int unsigned BIT_HIDDEN = 26;
    localparam int unsigned BIT_LSB    = 3;
    localparam int unsigned BIT_G      = 2;
    localparam int unsigned BIT_R      = 1;
    localparam int unsigned BIT_S      = 0;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] ZERO    = 32'h0000_0000;

endpackage

// File: rtl/normaliza_ponto_flt_arredonda_rne.sv
// Combinational round-to-nearest-even of a normalized/denormalized mantissa;
// shared with the multiplier back-end.
module arredonda_rne
    import ponto_flt_pkg::*;
#(
    parameter int unsigned EXP_W  = 10,
    parameter int unsigned MANT_W = 28
) (
    input  logic [MANT_W-1:0]       mant,
    input  logic signed [EXP_W-1:0] expo,
    output logic [FRAC_BITS-1:0]    frac,
    output logic signed [EXP_W-1:0] exp_adj,
    output logic                    hidden,
    output logic                    carry,
    output logic                    inexact
);

    localparam logic signed [EXP_W-1:0] E_UM = EXP_W'(1);

    logic             g, r, st, lsb, incr;
    logic [MANT_W-4:0] soma;

    always_comb begin
        g       = mant[BIT_G];
        r       = mant[BIT_R];
        st      = mant[BIT_S];
        lsb     = mant[BIT_LSB];
        incr    = g & (r | st | lsb);
        inexact = g | r | st;
        // soma[i] holds mantissa bit i+3: soma[24] is carry, soma[23] is hidden
        soma    = mant[MANT_W-1:BIT_LSB] + {{(MANT_W-4){1'b0}}, incr};
        carry   = soma[MANT_W-4];
        if (carry) begin
            frac    = soma[FRAC_BITS:1];
            hidden  = 1'b1;
            exp_adj = expo + E_UM;
        end else begin
            frac    = soma[FRAC_BITS-1:0];
            hidden  = soma[FRAC_BITS];
            exp_adj = expo;
        end
    end

endmodule

// File: rtl/normaliza_ponto_flt.sv
// Floating-point back-end: iterative normalization, RNE rounding and binary32
// packing behind valid/ready handshakes, one operation in flight.
module normaliza_ponto_flt
    import ponto_flt_pkg::*;
#(
    parameter int unsigned EXP_W  = 10,
    parameter int unsigned MANT_W = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sinal_in,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic [MANT_W-1:0]       mant_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             s,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    localparam logic signed [EXP_W-1:0] E_UM  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(EXP_MAX);

    estado_t estado, prox_estado;

    logic                    sinal_r;
    logic signed [EXP_W-1:0] e_r, e_prox;
    logic [MANT_W-1:0]       m_r, m_prox;
    logic                    norm_fim;

    logic [FRAC_BITS-1:0]    rne_frac;
    logic signed [EXP_W-1:0] rne_exp;
    logic                    rne_hidden, rne_carry, rne_inexact;

    logic [EXP_BITS-1:0]     campo_exp;
    logic [31:0]             s_prox;
    logic                    ovf_prox, unf_prox, inx_prox;

    arredonda_rne #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_rne (
        .mant    (m_r),
        .expo    (e_r),
        .frac    (rne_frac),
        .exp_adj (rne_exp),
        .hidden  (rne_hidden),
        .carry   (rne_carry),
        .inexact (rne_inexact)
    );

    // One normalization step per cycle; right shifts fold the lost bit into sticky.
    always_comb begin
        m_prox   = m_r;
        e_prox   = e_r;
        norm_fim = 1'b0;
        if (m_r == '0) begin
            norm_fim = 1'b1;
        end else if (m_r[BIT_CARRY] || (e_r < E_UM)) begin
            m_prox = {1'b0, m_r[MANT_W-1:2], m_r[1] | m_r[0]};
            e_prox = e_r + E_UM;
        end else if (!m_r[BIT_HIDDEN] && (e_r > E_UM)) begin
            m_prox = {m_r[MANT_W-2:0], 1'b0};
            e_prox = e_r - E_UM;
        end else begin
            norm_fim = 1'b1;
        end
    end

    always_comb begin
        campo_exp = (rne_hidden | rne_carry) ? rne_exp[EXP_BITS-1:0] : '0;
        s_prox    = {sinal_r, campo_exp, rne_frac};
        ovf_prox  = 1'b0;
        inx_prox  = rne_inexact;
        unf_prox  = rne_inexact & (campo_exp == '0);
        if (m_r == '0) begin
            s_prox   = sinal_r ? {1'b1, ZERO[30:0]} : ZERO;
            inx_prox = 1'b0;
            unf_prox = 1'b0;
        end else if (rne_exp >= E_MAX) begin
            s_prox   = sinal_r ? NEG_INF : POS_INF;
            ovf_prox = 1'b1;
            inx_prox = 1'b1;
            unf_prox = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            IDLE:    if (in_valid) prox_estado = NORM;
            NORM:    if (norm_fim) prox_estado = ROUND;
            ROUND:   prox_estado = DONE;
            DONE:    if (out_ready) prox_estado = IDLE;
            default: prox_estado = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (estado == IDLE);
        out_valid = (estado == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinal_r   <= 1'b0;
            e_r       <= '0;
            m_r       <= '0;
            s         <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (in_valid) begin
                        sinal_r <= sinal_in;
                        e_r     <= exp_in;
                        m_r     <= mant_in;
                    end
                end
                NORM: begin
                    m_r <= m_prox;
                    e_r <= e_prox;
                end
                ROUND: begin
                    s         <= s_prox;
                    overflow  <= ovf_prox;
                    underflow <= unf_prox;
                    inexact   <= inx_prox;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normaliza_ponto_flt.sv
// Directed self-checking bench for normaliza_ponto_flt.
module tb_normaliza_ponto_flt;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              sinal_in;
    logic signed [9:0] exp_in;
    logic [27:0]       mant_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       s;
    logic              overflow;
    logic              underflow;
    logic              inexact;

    int n_checks = 0;
    int n_erros  = 0;

    normaliza_ponto_flt #(
        .EXP_W  (10),
        .MANT_W (28)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sinal_in  (sinal_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    // flags_esp = {overflow, underflow, inexact}; lat_esp counts from the accepting cycle.
    task automatic executa(input string tag, input logic sg, input logic signed [9:0] e,
                           input logic [27:0] m, input logic [31:0] s_esp,
                           input logic [2:0] flags_esp, input int lat_esp, input int espera);
        int lat;
        @(negedge clk);
        verifica({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        sinal_in = sg;
        exp_in   = e;
        mant_in  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        verifica({tag, "_lat"}, 32'(lat), 32'(lat_esp));
        verifica({tag, "_s"}, s, s_esp);
        verifica({tag, "_flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, flags_esp});
        for (int i = 0; i < espera; i++) begin
            @(posedge clk);
            #1;
            verifica({tag, "_hold_s"}, s, s_esp);
            verifica({tag, "_hold_busy"}, {30'd0, out_valid, in_ready}, 32'b10);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        verifica({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic espurio;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sinal_in  = 1'b0;
        exp_in    = '0;
        mant_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        verifica("reset_state", {28'd0, in_ready, out_valid, overflow, underflow | inexact}, 32'b1000);
        verifica("reset_s", s, 32'h0);
        rst_n = 1'b1;

        executa("one",        1'b0, 10'sd127, 28'h4000000, 32'h3F80_0000, 3'b000, 3, 0);
        executa("carry",      1'b0, 10'sd127, 28'h8000000, 32'h4000_0000, 3'b000, 4, 0);
        executa("left3",      1'b0, 10'sd130, 28'h0800000, 32'h3F80_0000, 3'b000, 6, 0);
        executa("rne_tie",    1'b0, 10'sd127, 28'h4000004, 32'h3F80_0000, 3'b001, 3, 5);
        executa("rne_up",     1'b0, 10'sd127, 28'h400000C, 32'h3F80_0002, 3'b001, 3, 0);
        executa("rne_neg",    1'b1, 10'sd127, 28'h4000005, 32'hBF80_0001, 3'b001, 3, 0);
        executa("rne_carry",  1'b0, 10'sd127, 28'h7FFFFFC, 32'h4000_0000, 3'b001, 3, 0);
        executa("inf",        1'b0, 10'sd255, 28'h4000000, 32'h7F80_0000, 3'b101, 3, 0);
        executa("inf_carry",  1'b0, 10'sd254, 28'h8000000, 32'h7F80_0000, 3'b101, 4, 0);
        executa("neg_zero",   1'b1, 10'sd0,   28'h0000000, 32'h8000_0000, 3'b000, 3, 0);
        executa("denorm",     1'b0, -10'sd1,  28'h4000001, 32'h0020_0000, 3'b011, 5, 0);
        executa("sub_direct", 1'b0, 10'sd1,   28'h2000000, 32'h0040_0000, 3'b000, 3, 0);
        executa("sub_to_norm",1'b0, 10'sd1,   28'h3FFFFFC, 32'h0080_0000, 3'b001, 3, 0);

        // out_ready while idle must not disturb the FSM
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        verifica("idle_out_ready", {30'd0, out_valid, in_ready}, 32'b01);

        // abort an operation while it is still normalizing
        @(negedge clk);
        exp_in   = 10'sd130;
        mant_in  = 28'h0800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        verifica("abort_handshake", {30'd0, out_valid, in_ready}, 32'b01);
        verifica("abort_s", s, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        espurio = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) espurio = 1'b1;
        end
        verifica("abort_no_result", 32'(espurio), 32'd0);

        executa("after_abort", 1'b0, 10'sd128, 28'h4000000, 32'h4000_0000, 3'b000, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule
